// File: rtl/stall_pkg.sv
// stall_pkg: shared constants and types for the pipeline hold/bubble controller.
//
// Contents:
//   - stage index constants (PC..MEM) for the default 6-stage pipeline
//   - stall cause index constants
//   - fence.i sequencing FSM state type
//   - default origin-stage vector for the five external stall causes
package stall_pkg;

    // Pipeline stage indices (default configuration).
    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_DC  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_EX2 = 4;
    localparam int unsigned STG_MEM = 5;

    localparam int unsigned DEF_NUM_STAGES = 6;
    localparam int unsigned DEF_NUM_CAUSES = 5;
    localparam int unsigned DEF_STAGE_W    = $clog2(DEF_NUM_STAGES);

    // Stall cause indices into stall_req.
    localparam int unsigned CAUSE_LD_MISS = 0;
    localparam int unsigned CAUSE_ST_MISS = 1;
    localparam int unsigned CAUSE_DIV     = 2;
    localparam int unsigned CAUSE_IC_MISS = 3;
    localparam int unsigned CAUSE_SPARE   = 4;

    // Origin stage per cause, cause 0 in the least significant field:
    // load miss=MEM, store miss=MEM, div=EX, icache miss=IF, spare=MEM.
    localparam logic [DEF_NUM_CAUSES*DEF_STAGE_W-1:0] DEF_CAUSE_STAGE = {
        3'(STG_MEM),  // spare
        3'(STG_IF),   // icache miss
        3'(STG_EX),   // div busy
        3'(STG_MEM),  // store miss
        3'(STG_MEM)   // load miss
    };

    // fence.i sequencing: drain stores, invalidate icache, refetch.
    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StInval,
        StResume
    } fence_state_e;

endpackage

// File: rtl/stall_perf_cnt.sv
// stall_perf_cnt: per-cause saturating stall-cycle counters, read mux and
// commit-stall watchdog.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   inc         - one increment request per counter (level, per cycle)
//   wdt_hold    - last-stage hold; watchdog counts consecutive cycles of it
//   perf_clr    - synchronous clear of all counters, watchdog and hang flag
//   perf_sel    - counter select; out-of-range selects read zero
//   perf_cnt    - selected counter value
//   wdt_hang    - sticky hang flag
module stall_perf_cnt
    import stall_pkg::*;
#(
    parameter int unsigned NUM_CNT    = 7,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned WDT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CNT-1:0]   inc,
    input  logic                 wdt_hold,
    input  logic                 perf_clr,
    input  logic [SEL_W-1:0]     perf_sel,
    output logic [CNT_WIDTH-1:0] perf_cnt,
    output logic                 wdt_hang
);

    localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
    logic [WDT_W-1:0]     wdt_q, wdt_d;
    logic                 hang_q, hang_d;

    // Counter bank: clear wins over increment, increments stop at all-ones.
    always_comb begin
        for (int k = 0; k < NUM_CNT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (perf_clr) begin
                cnt_d[k] = '0;
            end else if (inc[k] && (cnt_q[k] != '1)) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    // Watchdog: count parks at WDT_LAST while the hold persists, so the hang
    // flag is raised on the WDT_CYCLES-th consecutive held cycle.
    always_comb begin
        wdt_d  = wdt_q;
        hang_d = hang_q;
        if (perf_clr) begin
            wdt_d  = '0;
            hang_d = 1'b0;
        end else if (wdt_hold) begin
            if (wdt_q == WDT_LAST) begin
                hang_d = 1'b1;
            end else begin
                wdt_d = wdt_q + 1'b1;
            end
        end else begin
            wdt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                cnt_q[k] <= '0;
            end
            wdt_q  <= '0;
            hang_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CNT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            wdt_q  <= wdt_d;
            hang_q <= hang_d;
        end
    end

    always_comb begin
        perf_cnt = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (perf_sel == SEL_W'(k)) begin
                perf_cnt = cnt_q[k];
            end
        end
    end

    assign wdt_hang = hang_q;

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline hold/bubble controller.
//
// Each active stall source holds every stage at or upstream of its origin
// stage; the first stage below the held region receives a bubble. A fence.i
// FSM drains stores, invalidates the icache and flushes the front end, and a
// perf block counts stall cycles and watches for a stuck commit stage.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   stall_req         - level stall request per cause
//   load_hazard       - load in EX / EX2 has a RAW hazard with DC
//   branch_taken_kill - taken branch downstream, suppresses load hazards
//   fencei_req        - valid fence.i sitting in DC
//   store_buf_empty   - no pending stores or dirty writebacks
//   icache_inv_ack    - icache invalidate complete
//   commit_en_in      - raw WB commit enables
//   cancel_wb         - WB instruction cancelled
//   interrupt_taken   - interrupt taken this cycle
//   perf_sel/perf_clr - counter select / synchronous clear
//   hold, bubble      - per-stage hold and bubble
//   can_not_issue     - DC must not issue
//   fencei_busy       - fence FSM not idle
//   icache_inv_req    - icache invalidate request
//   flush_front       - one-cycle PC/IF flush for refetch
//   commit_en_out     - gated commit enables
//   perf_cnt          - selected counter
//   wdt_hang          - sticky watchdog flag
module stall_ctrl
    import stall_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 6,
    parameter int unsigned NUM_CAUSES = 5,
    parameter logic [NUM_CAUSES*$clog2(NUM_STAGES)-1:0] CAUSE_STAGE = DEF_CAUSE_STAGE,
    parameter int unsigned DC_STAGE   = STG_DC,
    parameter int unsigned NUM_LD_SRC = 2,
    parameter int unsigned NUM_COMMIT = 5,
    parameter logic [NUM_COMMIT-1:0] INT_GATE_MASK = 5'b00011,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned WDT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_CAUSES-1:0]               stall_req,
    input  logic [NUM_LD_SRC-1:0]               load_hazard,
    input  logic                                branch_taken_kill,
    input  logic                                fencei_req,
    input  logic                                store_buf_empty,
    input  logic                                icache_inv_ack,
    input  logic [NUM_COMMIT-1:0]               commit_en_in,
    input  logic                                cancel_wb,
    input  logic                                interrupt_taken,
    input  logic [$clog2(NUM_CAUSES+2)-1:0]     perf_sel,
    input  logic                                perf_clr,
    output logic [NUM_STAGES-1:0]               hold,
    output logic [NUM_STAGES-1:0]               bubble,
    output logic                                can_not_issue,
    output logic                                fencei_busy,
    output logic                                icache_inv_req,
    output logic                                flush_front,
    output logic [NUM_COMMIT-1:0]               commit_en_out,
    output logic [CNT_WIDTH-1:0]                perf_cnt,
    output logic                                wdt_hang
);

    localparam int unsigned SW      = $clog2(NUM_STAGES);
    localparam int unsigned NUM_CNT = NUM_CAUSES + 2;
    localparam logic [SW-1:0] DC_IDX = SW'(DC_STAGE);

    fence_state_e state_q;
    logic         inv_req_q;
    logic         flush_q;
    logic         busy_q;

    logic          ld_active;
    logic          fence_hold;
    logic          any_active;
    logic [SW-1:0] origin_max;

    assign ld_active  = (|load_hazard) & ~branch_taken_kill;
    assign fence_hold = (state_q == StDrain) || (state_q == StInval);

    // Deepest origin among active sources; load hazards and an in-flight
    // fence both originate in DC.
    always_comb begin
        any_active = 1'b0;
        origin_max = '0;
        for (int k = 0; k < NUM_CAUSES; k++) begin
            if (stall_req[k]) begin
                any_active = 1'b1;
                if (CAUSE_STAGE[k*SW +: SW] > origin_max) begin
                    origin_max = CAUSE_STAGE[k*SW +: SW];
                end
            end
        end
        if (ld_active || fence_hold) begin
            any_active = 1'b1;
            if (DC_IDX > origin_max) begin
                origin_max = DC_IDX;
            end
        end
    end

    always_comb begin
        hold   = '0;
        bubble = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            hold[s] = any_active && (SW'(s) <= origin_max);
        end
        for (int s = 1; s < NUM_STAGES; s++) begin
            bubble[s] = hold[s-1] & ~hold[s];
        end
    end

    assign can_not_issue = hold[DC_STAGE];

    // A held last stage, a cancelled WB or (for masked bits) an interrupt
    // all suppress commit.
    assign commit_en_out = commit_en_in
                         & ~{NUM_COMMIT{hold[NUM_STAGES-1] | cancel_wb}}
                         & ~(INT_GATE_MASK & {NUM_COMMIT{interrupt_taken}});

    // Fence FSM with registered outputs. It is independent of the hold
    // vector so a fence keeps progressing behind other stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            inv_req_q <= 1'b0;
            flush_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fencei_req) begin
                        state_q <= StDrain;
                        busy_q  <= 1'b1;
                    end
                end
                StDrain: begin
                    if (store_buf_empty) begin
                        state_q   <= StInval;
                        inv_req_q <= 1'b1;
                    end
                end
                StInval: begin
                    if (icache_inv_ack) begin
                        state_q   <= StResume;
                        inv_req_q <= 1'b0;
                        flush_q   <= 1'b1;
                    end
                end
                StResume: begin
                    state_q <= StIdle;
                    flush_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    inv_req_q <= 1'b0;
                    flush_q   <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign fencei_busy    = busy_q;
    assign icache_inv_req = inv_req_q;
    assign flush_front    = flush_q;

    stall_perf_cnt #(
        .NUM_CNT    (NUM_CNT),
        .SEL_W      ($clog2(NUM_CAUSES + 2)),
        .CNT_WIDTH  (CNT_WIDTH),
        .WDT_CYCLES (WDT_CYCLES)
    ) u_perf (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      ({busy_q, ld_active, stall_req}),
        .wdt_hold (hold[NUM_STAGES-1]),
        .perf_clr (perf_clr),
        .perf_sel (perf_sel),
        .perf_cnt (perf_cnt),
        .wdt_hang (wdt_hang)
    );

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl (default parameters).
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  stall_req;
    logic [1:0]  load_hazard;
    logic        branch_taken_kill;
    logic        fencei_req;
    logic        store_buf_empty;
    logic        icache_inv_ack;
    logic [4:0]  commit_en_in;
    logic        cancel_wb;
    logic        interrupt_taken;
    logic [2:0]  perf_sel;
    logic        perf_clr;
    logic [5:0]  hold;
    logic [5:0]  bubble;
    logic        can_not_issue;
    logic        fencei_busy;
    logic        icache_inv_req;
    logic        flush_front;
    logic [4:0]  commit_en_out;
    logic [31:0] perf_cnt;
    logic        wdt_hang;

    int n_checks = 0;
    int n_pass   = 0;

    stall_ctrl u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_req         (stall_req),
        .load_hazard       (load_hazard),
        .branch_taken_kill (branch_taken_kill),
        .fencei_req        (fencei_req),
        .store_buf_empty   (store_buf_empty),
        .icache_inv_ack    (icache_inv_ack),
        .commit_en_in      (commit_en_in),
        .cancel_wb         (cancel_wb),
        .interrupt_taken   (interrupt_taken),
        .perf_sel          (perf_sel),
        .perf_clr          (perf_clr),
        .hold              (hold),
        .bubble            (bubble),
        .can_not_issue     (can_not_issue),
        .fencei_busy       (fencei_busy),
        .icache_inv_req    (icache_inv_req),
        .flush_front       (flush_front),
        .commit_en_out     (commit_en_out),
        .perf_cnt          (perf_cnt),
        .wdt_hang          (wdt_hang)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        rst_n             = 1'b0;
        stall_req         = '0;
        load_hazard       = '0;
        branch_taken_kill = 1'b0;
        fencei_req        = 1'b0;
        store_buf_empty   = 1'b0;
        icache_inv_ack    = 1'b0;
        commit_en_in      = 5'b10101;
        cancel_wb         = 1'b0;
        interrupt_taken   = 1'b0;
        perf_sel          = 3'd0;
        perf_clr          = 1'b0;
        load_hazard       = 2'b01;

        // Reset state; combinational paths still follow inputs.
        #2;
        check_eq("rst_busy",      32'(fencei_busy), 32'd0);
        check_eq("rst_inv_req",   32'(icache_inv_req), 32'd0);
        check_eq("rst_flush",     32'(flush_front), 32'd0);
        check_eq("rst_hang",      32'(wdt_hang), 32'd0);
        check_eq("rst_perf_cnt",  perf_cnt, 32'd0);
        check_eq("rst_hold_comb", 32'(hold), 32'h07);
        check_eq("rst_commit",    32'(commit_en_out), 32'h15);
        tick();
        tick();
        load_hazard  = '0;
        commit_en_in = 5'b11111;
        rst_n        = 1'b1;
        tick();

        // Div stall (origin EX) for 4 cycles.
        stall_req = 5'b00100;
        #1;
        check_eq("div_hold",    32'(hold), 32'h0f);
        check_eq("div_bubble",  32'(bubble), 32'h10);
        check_eq("div_cni",     32'(can_not_issue), 32'd1);
        check_eq("div_commit",  32'(commit_en_out), 32'h1f);
        repeat (4) tick();
        stall_req = '0;
        perf_sel  = 3'd2;
        #1;
        check_eq("div_cnt",      perf_cnt, 32'd4);
        check_eq("div_released", 32'(hold), 32'h00);
        perf_sel = 3'd7;
        #1;
        check_eq("sel_oor", perf_cnt, 32'd0);

        // Load hazards, combinations and kill suppression.
        load_hazard = 2'b01;
        #1;
        check_eq("ld0_hold",   32'(hold), 32'h07);
        check_eq("ld0_bubble", 32'(bubble), 32'h08);
        check_eq("ld0_cni",    32'(can_not_issue), 32'd1);
        load_hazard = 2'b10;
        #1;
        check_eq("ld1_hold", 32'(hold), 32'h07);
        stall_req = 5'b00100;
        #1;
        check_eq("ld_div_hold", 32'(hold), 32'h0f);
        stall_req = 5'b00001;
        #1;
        check_eq("ld_lmiss_hold",   32'(hold), 32'h3f);
        check_eq("ld_lmiss_bubble", 32'(bubble), 32'h00);
        check_eq("ld_lmiss_commit", 32'(commit_en_out), 32'h00);
        stall_req   = '0;
        load_hazard = 2'b01;
        repeat (2) tick();
        branch_taken_kill = 1'b1;
        #1;
        check_eq("kill_hold",   32'(hold), 32'h00);
        check_eq("kill_bubble", 32'(bubble), 32'h00);
        check_eq("kill_cni",    32'(can_not_issue), 32'd0);
        tick();
        load_hazard       = '0;
        branch_taken_kill = 1'b0;
        perf_sel          = 3'd5;
        #1;
        check_eq("ld_cnt", perf_cnt, 32'd2);

        // fence.i: 3 drain cycles, 2 invalidate cycles, 1 resume cycle.
        fencei_req = 1'b1;
        #1;
        check_eq("fence_idle_hold", 32'(hold), 32'h00);
        tick();
        fencei_req = 1'b0;
        check_eq("drain_busy", 32'(fencei_busy), 32'd1);
        check_eq("drain_hold", 32'(hold), 32'h07);
        check_eq("drain_inv",  32'(icache_inv_req), 32'd0);
        stall_req = 5'b00100;
        #1;
        check_eq("drain_div_hold", 32'(hold), 32'h0f);
        stall_req = '0;
        tick();
        check_eq("drain2_cni", 32'(can_not_issue), 32'd1);
        tick();
        check_eq("drain3_inv", 32'(icache_inv_req), 32'd0);
        store_buf_empty = 1'b1;
        tick();
        check_eq("inval_req",  32'(icache_inv_req), 32'd1);
        check_eq("inval_hold", 32'(hold), 32'h07);
        tick();
        check_eq("inval2_req", 32'(icache_inv_req), 32'd1);
        icache_inv_ack = 1'b1;
        tick();
        icache_inv_ack = 1'b0;
        check_eq("resume_flush", 32'(flush_front), 32'd1);
        check_eq("resume_inv",   32'(icache_inv_req), 32'd0);
        check_eq("resume_hold",  32'(hold), 32'h00);
        check_eq("resume_busy",  32'(fencei_busy), 32'd1);
        tick();
        check_eq("idle_flush", 32'(flush_front), 32'd0);
        check_eq("idle_busy",  32'(fencei_busy), 32'd0);
        perf_sel = 3'd6;
        #1;
        check_eq("fence_cnt", perf_cnt, 32'd6);

        // Commit gating.
        interrupt_taken = 1'b1;
        #1;
        check_eq("int_commit", 32'(commit_en_out), 32'h1c);
        cancel_wb = 1'b1;
        #1;
        check_eq("cancel_commit", 32'(commit_en_out), 32'h00);
        interrupt_taken = 1'b0;
        cancel_wb       = 1'b0;
        #1;
        check_eq("free_commit", 32'(commit_en_out), 32'h1f);

        // Watchdog: last-stage hold for 1024 consecutive cycles.
        stall_req = 5'b00001;
        bad = 0;
        repeat (1023) begin
            tick();
            if (commit_en_out !== 5'b00000) bad++;
        end
        check_eq("wdt_commit_gated", 32'(bad), 32'd0);
        check_eq("wdt_1023", 32'(wdt_hang), 32'd0);
        tick();
        check_eq("wdt_1024", 32'(wdt_hang), 32'd1);
        stall_req = '0;
        perf_sel  = 3'd0;
        #1;
        check_eq("lmiss_cnt", perf_cnt, 32'd1024);
        tick();
        check_eq("wdt_sticky", 32'(wdt_hang), 32'd1);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        check_eq("clr_hang", 32'(wdt_hang), 32'd0);
        check_eq("clr_cnt0", perf_cnt, 32'd0);
        perf_sel = 3'd2;
        #1;
        check_eq("clr_cnt2", perf_cnt, 32'd0);

        // Asynchronous reset in the middle of an invalidate.
        fencei_req = 1'b1;
        tick();
        fencei_req = 1'b0;
        tick();
        check_eq("pre_rst_inv", 32'(icache_inv_req), 32'd1);
        perf_sel = 3'd6;
        rst_n    = 1'b0;
        #1;
        check_eq("async_inv", 32'(icache_inv_req), 32'd0);
        check_eq("async_busy", 32'(fencei_busy), 32'd0);
        check_eq("async_cnt", perf_cnt, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_busy", 32'(fencei_busy), 32'd0);
        check_eq("post_rst_hold", 32'(hold), 32'h00);
        check_eq("post_rst_cnt",  perf_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
